// File: rtl/ps2_rx_core.sv
// PS/2 device-to-host receiver: synchronised, glitch-filtered clock, frame FSM and FWFT byte FIFO.
// Define PS2_PARITY_CHK_EN to reject frames whose odd parity does not hold.
module ps2_rx_core #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        en_i,
    input  logic                        ps2_clk_i,
    input  logic                        ps2_dat_i,
    input  logic                        rd_en_i,
    input  logic                        clr_i,
    output logic [7:0]                  dat_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [$clog2(FIFO_DEPTH):0] cnt_o,
    output logic                        ovf_o,
    output logic                        frm_err_o,
    output logic                        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    logic [1:0]    clkSync_q, datSync_q;
    logic          filtClk_q, filtClk_d, filtPrev_q;
    logic [FW-1:0] filtCnt_q, filtCnt_d;
    logic          strobe, sdat;

    state_e        state_q, state_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] toCnt_q, toCnt_d;
    logic          push, frmSet, frameOk;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [AW:0]   cnt_q;
    logic          doPush, doPop, ovfSet, ovf_q, frmErr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clkSync_q  <= 2'b11;
            datSync_q  <= 2'b11;
            filtClk_q  <= 1'b1;
            filtPrev_q <= 1'b1;
            filtCnt_q  <= '0;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            datSync_q  <= {datSync_q[0], ps2_dat_i};
            filtClk_q  <= filtClk_d;
            filtPrev_q <= filtClk_q;
            filtCnt_q  <= filtCnt_d;
        end
    end

    // The filtered clock only moves once the synchronised line has disagreed for FILT_LEN samples in a row.
    always_comb begin
        filtClk_d = filtClk_q;
        filtCnt_d = '0;
        if (clkSync_q[1] != filtClk_q) begin
            if (filtCnt_q == FW'(FILT_LEN - 1)) filtClk_d = ~filtClk_q;
            else                                filtCnt_d = filtCnt_q + FW'(1);
        end
    end

    assign strobe = en_i & filtPrev_q & ~filtClk_q;
    assign sdat   = datSync_q[1];

`ifdef PS2_PARITY_CHK_EN
    assign frameOk = sdat & (^{shift_q, parity_q});
`else
    assign frameOk = sdat;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            toCnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            toCnt_q  <= toCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        toCnt_d  = '0;
        push     = 1'b0;
        frmSet   = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            if (state_q != IDLE && !strobe) toCnt_d = toCnt_q + TW'(1);
            case (state_q)
                IDLE: if (strobe && !sdat) begin
                    state_d  = DATA;
                    bitCnt_d = '0;
                end
                DATA: if (strobe) begin
                    shift_d  = {sdat, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: if (strobe) begin
                    parity_d = sdat;
                    state_d  = STOP;
                end
                STOP: if (strobe) begin
                    push    = frameOk;
                    frmSet  = ~frameOk;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // A stalled line abandons the partial frame so the next start bit is recognised.
            if (state_q != IDLE && !strobe && toCnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                toCnt_d = '0;
                frmSet  = 1'b1;
            end
        end
    end

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    assign doPop   = rd_en_i & ~empty_o;
    assign doPush  = push & (~full_o | doPop);
    assign ovfSet  = push & full_o & ~rd_en_i;

    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q] <= shift_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            frmErr_q <= 1'b0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
            if (doPush && !doPop)      cnt_q <= cnt_q + (AW + 1)'(1);
            else if (doPop && !doPush) cnt_q <= cnt_q - (AW + 1)'(1);
            if (ovfSet)     ovf_q <= 1'b1;
            else if (clr_i) ovf_q <= 1'b0;
            if (frmSet)     frmErr_q <= 1'b1;
            else if (clr_i) frmErr_q <= 1'b0;
        end
    end

    assign dat_o     = empty_o ? 8'h00 : mem_q[rdPtr_q];
    assign cnt_o     = cnt_q;
    assign ovf_o     = ovf_q;
    assign frm_err_o = frmErr_q;
    assign irq_o     = ~empty_o | ovf_q | frmErr_q;

endmodule

// File: tb/tb_ps2_rx_core.sv
// Directed bench for ps2_rx_core: frames are bit-banged on the PS/2 lines with hand-computed expectations.
module tb_ps2_rx_core;

    localparam int HALF = 20;
    localparam int TMO  = 20000;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic       ps2Clk = 1'b1, ps2Dat = 1'b1, rdEn = 1'b0, clr = 1'b0;
    logic [7:0] datO;
    logic       emptyO, fullO, ovfO, frmErrO, irqO;
    logic [3:0] cntO;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ps2_rx_core #(.FIFO_DEPTH(8), .FILT_LEN(4), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .ps2_clk_i(ps2Clk), .ps2_dat_i(ps2Dat),
        .rd_en_i(rdEn), .clr_i(clr), .dat_o(datO), .empty_o(emptyO), .full_o(fullO),
        .cnt_o(cntO), .ovf_o(ovfO), .frm_err_o(frmErrO), .irq_o(irqO)
    );

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic glitch();
        ps2Clk = 1'b0;
        waitCycles(2);
        ps2Clk = 1'b1;
        waitCycles(4);
    endtask

    // Sends bits[0..n-1]; a 2-cycle clock glitch is inserted before bit glitchAt.
    task automatic sendBits(input logic [10:0] bits, input int n, input int glitchAt);
        for (int i = 0; i < n; i++) begin
            ps2Dat = bits[i];
            if (i == glitchAt) glitch();
            waitCycles(HALF);
            ps2Clk = 1'b0;
            waitCycles(HALF);
            ps2Clk = 1'b1;
        end
        waitCycles(HALF);
        ps2Dat = 1'b1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    task automatic sendByte(input logic [7:0] d);
        sendBits(frame(d, ~^d, 1'b1), 11, -1);
    endtask

    task automatic popOne();
        rdEn = 1'b1;
        @(negedge clk);
        rdEn = 1'b0;
    endtask

    task automatic pulseClr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (datO !== 8'h00) begin errors++; $display("[TB] FAIL reset_dat got %h exp 00", datO); end
        checks++; if (emptyO !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b exp 1", emptyO); end
        checks++; if (fullO !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b exp 0", fullO); end
        checks++; if (cntO !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d exp 0", cntO); end
        checks++; if ({ovfO, frmErrO, irqO} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b exp 000", {ovfO, frmErrO, irqO}); end
        waitCycles(4);
        rst_n = 1'b1;
        en    = 1'b1;
        waitCycles(4);
    endtask

    task automatic test_single();
        sendByte(8'h1C);
        checks++; if (datO !== 8'h1C) begin errors++; $display("[TB] FAIL single_dat got %h exp 1c", datO); end
        checks++; if (cntO !== 4'd1) begin errors++; $display("[TB] FAIL single_cnt got %0d exp 1", cntO); end
        checks++; if (irqO !== 1'b1) begin errors++; $display("[TB] FAIL single_irq got %b exp 1", irqO); end
        checks++; if (frmErrO !== 1'b0) begin errors++; $display("[TB] FAIL single_frm got %b exp 0", frmErrO); end
        popOne();
        checks++; if (emptyO !== 1'b1) begin errors++; $display("[TB] FAIL single_pop_empty got %b exp 1", emptyO); end
        checks++; if (irqO !== 1'b0) begin errors++; $display("[TB] FAIL single_pop_irq got %b exp 0", irqO); end
        popOne();
        checks++; if (cntO !== 4'd0) begin errors++; $display("[TB] FAIL empty_pop_cnt got %0d exp 0", cntO); end
    endtask

    task automatic test_glitch();
        ps2Dat = 1'b0;
        for (int i = 0; i < 3; i++) glitch();
        ps2Dat = 1'b1;
        waitCycles(10);
        checks++; if ({cntO, frmErrO} !== 5'b0000_0) begin errors++; $display("[TB] FAIL glitch_idle got cnt %0d frm %b exp 0 0", cntO, frmErrO); end
        sendBits(frame(8'h5A, 1'b1, 1'b1), 11, 5);
        checks++; if (datO !== 8'h5A) begin errors++; $display("[TB] FAIL glitch_dat got %h exp 5a", datO); end
        checks++; if (cntO !== 4'd1) begin errors++; $display("[TB] FAIL glitch_cnt got %0d exp 1", cntO); end
        checks++; if (frmErrO !== 1'b0) begin errors++; $display("[TB] FAIL glitch_frm got %b exp 0", frmErrO); end
        popOne();
    endtask

    task automatic test_stop_err();
        sendByte(8'h12);
        sendBits(frame(8'hAA, 1'b1, 1'b0), 11, -1);
        checks++; if (frmErrO !== 1'b1) begin errors++; $display("[TB] FAIL stop_frm got %b exp 1", frmErrO); end
        checks++; if (cntO !== 4'd1) begin errors++; $display("[TB] FAIL stop_cnt got %0d exp 1", cntO); end
        checks++; if (datO !== 8'h12) begin errors++; $display("[TB] FAIL stop_dat got %h exp 12", datO); end
        pulseClr();
        checks++; if (frmErrO !== 1'b0) begin errors++; $display("[TB] FAIL stop_clr got %b exp 0", frmErrO); end
        checks++; if (irqO !== 1'b1) begin errors++; $display("[TB] FAIL stop_irq got %b exp 1", irqO); end
        popOne();
        checks++; if (irqO !== 1'b0) begin errors++; $display("[TB] FAIL stop_irq_pop got %b exp 0", irqO); end
    endtask

    task automatic test_parity();
        sendBits(frame(8'h55, 1'b0, 1'b1), 11, -1);
`ifdef PS2_PARITY_CHK_EN
        checks++; if (frmErrO !== 1'b1) begin errors++; $display("[TB] FAIL parity_frm got %b exp 1", frmErrO); end
        checks++; if (cntO !== 4'd0) begin errors++; $display("[TB] FAIL parity_cnt got %0d exp 0", cntO); end
`else
        checks++; if (frmErrO !== 1'b0) begin errors++; $display("[TB] FAIL parity_frm got %b exp 0", frmErrO); end
        checks++; if (datO !== 8'h55) begin errors++; $display("[TB] FAIL parity_dat got %h exp 55", datO); end
`endif
        pulseClr();
        popOne();
        checks++; if (emptyO !== 1'b1) begin errors++; $display("[TB] FAIL parity_empty got %b exp 1", emptyO); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) sendByte(8'(i));
        checks++; if ({fullO, ovfO, cntO} !== 6'b10_1000) begin errors++; $display("[TB] FAIL ovf_full8 got full %b ovf %b cnt %0d exp 1 0 8", fullO, ovfO, cntO); end
        sendByte(8'h09);
        checks++; if (fullO !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got %b exp 1", fullO); end
        checks++; if (ovfO !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b exp 1", ovfO); end
        checks++; if (datO !== 8'h01) begin errors++; $display("[TB] FAIL ovf_head got %h exp 01", datO); end
        checks++; if (cntO !== 4'd8) begin errors++; $display("[TB] FAIL ovf_cnt got %0d exp 8", cntO); end
        pulseClr();
        checks++; if (ovfO !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clr got %b exp 0", ovfO); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (datO !== 8'(i)) begin errors++; $display("[TB] FAIL ovf_drain got %h exp %h", datO, 8'(i)); end
            popOne();
        end
        checks++; if (emptyO !== 1'b1) begin errors++; $display("[TB] FAIL ovf_drained got %b exp 1", emptyO); end
    endtask

    task automatic test_timeout();
        sendBits(frame(8'hFF, 1'b1, 1'b1), 5, -1);
        waitCycles(TMO - 100);
        checks++; if (frmErrO !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early got %b exp 0", frmErrO); end
        waitCycles(150);
        checks++; if (frmErrO !== 1'b1) begin errors++; $display("[TB] FAIL timeout_frm got %b exp 1", frmErrO); end
        checks++; if (cntO !== 4'd0) begin errors++; $display("[TB] FAIL timeout_cnt got %0d exp 0", cntO); end
        pulseClr();
        sendByte(8'h29);
        checks++; if (datO !== 8'h29) begin errors++; $display("[TB] FAIL timeout_next got %h exp 29", datO); end
        checks++; if ({cntO, frmErrO} !== 5'b0001_0) begin errors++; $display("[TB] FAIL timeout_next_st got cnt %0d frm %b exp 1 0", cntO, frmErrO); end
        popOne();
    endtask

    task automatic test_enable();
        sendByte(8'h3C);
        en = 1'b0;
        sendByte(8'h77);
        checks++; if (cntO !== 4'd1) begin errors++; $display("[TB] FAIL en_cnt got %0d exp 1", cntO); end
        checks++; if (datO !== 8'h3C) begin errors++; $display("[TB] FAIL en_dat got %h exp 3c", datO); end
        popOne();
        checks++; if (emptyO !== 1'b1) begin errors++; $display("[TB] FAIL en_read got %b exp 1", emptyO); end
        en = 1'b1;
        sendBits(frame(8'hFF, 1'b1, 1'b1), 5, -1);
        en = 1'b0;
        waitCycles(5);
        en = 1'b1;
        sendByte(8'h41);
        checks++; if (datO !== 8'h41) begin errors++; $display("[TB] FAIL en_abort_dat got %h exp 41", datO); end
        checks++; if (frmErrO !== 1'b0) begin errors++; $display("[TB] FAIL en_abort_frm got %b exp 0", frmErrO); end
        popOne();
    endtask

    task automatic test_reset_midframe();
        sendByte(8'h0F);
        sendBits(frame(8'hFF, 1'b1, 1'b1), 5, -1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({emptyO, cntO, irqO, datO} !== {1'b1, 4'd0, 1'b0, 8'h00}) begin errors++; $display("[TB] FAIL async_reset got empty %b cnt %0d irq %b dat %h exp 1 0 0 00", emptyO, cntO, irqO, datO); end
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(3);
        sendByte(8'h29);
        checks++; if (datO !== 8'h29) begin errors++; $display("[TB] FAIL midreset_dat got %h exp 29", datO); end
        checks++; if ({cntO, frmErrO} !== 5'b0001_0) begin errors++; $display("[TB] FAIL midreset_st got cnt %0d frm %b exp 1 0", cntO, frmErrO); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_stop_err();
        test_parity();
        test_overflow();
        test_timeout();
        test_enable();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_core.md
PS2_RX_CORE -- requirements
Module: ps2_rx_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: receive FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter FILT_LEN, default 4: consecutive equal samples needed to accept a ps2_clk level change; 1..16.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 20000: clk_i cycles without a ps2_clk falling edge that abort a frame.
REQ-004 SHALL have port clk_i, input, 1: single system clock; the block uses no other clock.
REQ-005 SHALL have port rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port en_i, input, 1: receiver enable.
REQ-007 SHALL have ports ps2_clk_i and ps2_dat_i, input, 1 each: asynchronous PS/2 lines.
REQ-008 SHALL have port rd_en_i, input, 1: pop the FIFO head.
REQ-009 SHALL have port clr_i, input, 1: clear sticky error flags.
REQ-010 SHALL have port dat_o, output, 8: FIFO head, first-word fall-through.
REQ-011 SHALL have ports empty_o and full_o, output, 1 each: FIFO status.
REQ-012 SHALL have port cnt_o, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-013 SHALL have ports ovf_o and frm_err_o, output, 1 each: sticky overflow and framing-error flags.
REQ-014 SHALL have port irq_o, output, 1: level interrupt, high while !empty_o or ovf_o or frm_err_o.

Function
REQ-015 SHALL pass both PS/2 inputs through 2-flop synchronisers.
REQ-016 SHALL flip the filtered clock only after FILT_LEN consecutive synchronised samples disagree with it; it resets to 1.
REQ-017 SHALL form a one-cycle sample strobe on each filtered-clock 1->0 transition and sample synchronised data in that cycle.
REQ-018 SHALL run an FSM with states IDLE, DATA, PARITY, STOP, reset to IDLE.
REQ-019 SHALL, in IDLE, go to DATA with bit counter 0 on a strobe sampling 0, and ignore a strobe sampling 1.
REQ-020 SHALL, in DATA, shift bits LSB first on each strobe and go to PARITY after the 8th bit.
REQ-021 SHALL, in PARITY, store the sampled bit and go to STOP on the next strobe.
REQ-022 SHALL, in STOP, push the byte on the next strobe if the stop bit is 1 (and parity is valid per REQ-034); otherwise set frm_err_o and push nothing; then return to IDLE.
REQ-023 SHALL make a pushed byte visible on dat_o/empty_o/cnt_o in the cycle after the STOP strobe.
REQ-024 SHALL count clk_i cycles while not IDLE, clear the count on each strobe, and at TIMEOUT_CYC discard the partial frame, return to IDLE and set frm_err_o.
REQ-025 SHALL treat rd_en_i while empty as a no-op.
REQ-026 SHALL, on a push while full with no simultaneous rd_en_i, drop the new byte, set ovf_o and leave FIFO contents unchanged.
REQ-027 SHALL, on a push and rd_en_i in the same cycle, perform both, including when full; cnt_o stays unchanged.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH.
REQ-029 SHALL clear ovf_o and frm_err_o on clr_i, with a same-cycle set taking priority.
REQ-030 SHALL, while en_i=0, force the FSM to IDLE (aborting any frame silently), ignore strobes and keep FIFO reads working.

Reset
REQ-031 SHALL, on rst_n_i low, asynchronously drive dat_o=0, empty_o=1, full_o=0, cnt_o=0, ovf_o=0, frm_err_o=0 and irq_o=0.
REQ-032 SHALL, on rst_n_i low, set FIFO pointers to 0, the FSM to IDLE, the filter and synchronisers to 1, and the timeout counter to 0.
REQ-033 SHALL discard any frame in progress when reset asserts mid-frame.

Configuration
REQ-034 SHALL check parity when PS2_PARITY_CHK_EN is defined: odd parity over data plus parity bit, mismatch treated as a frame error.
REQ-035 SHALL, when PS2_PARITY_CHK_EN is undefined, ignore the parity bit and push any frame with stop bit 1.

Verification
REQ-036 SHALL cover frame 0x1C, parity 0, stop 1 -> dat_o=0x1C, cnt_o=1, irq_o=1; one rd_en_i pulse -> empty_o=1.
REQ-037 SHALL cover 9 frames with FIFO_DEPTH=8 and no reads -> full_o=1, ovf_o=1, dat_o equals the 1st byte; clr_i -> ovf_o=0.
REQ-038 SHALL cover frame 0xAA with stop bit 0 -> frm_err_o=1 and cnt_o unchanged.
REQ-039 SHALL cover frame 0x55 with parity 0 -> frm_err_o=1 with PS2_PARITY_CHK_EN defined, byte pushed without it.
REQ-040 SHALL cover a frame stopped after 4 bits and held for TIMEOUT_CYC cycles -> frm_err_o=1 and FSM IDLE; the next frame 0x29 is received correctly.
REQ-041 SHALL cover 2-cycle ps2_clk_i glitches with FILT_LEN=4 -> no strobe and no state change.
